// File: rtl/rtc_bus_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rtc_bus_master : shadow-refresh and single-write master for the RTC A/D bus
// Revision 1.0
// ----------------------------------------------------------------------------
module rtc_bus_master #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       NREG        = 9,
  parameter logic [DATA_W-1:0] BASE_ADDR   = 8'h21,
  parameter int unsigned       T_PH        = 4,
  parameter int unsigned       REFRESH_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   refresh_en,
  input  logic                   wr_req,
  input  logic [DATA_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ack,
  output logic                   busy,
  output logic                   rd_valid,
  output logic [NREG*DATA_W-1:0] shadow,
  output logic                   CS,
  output logic                   A_D,
  output logic                   RD,
  output logic                   WR,
  inout  wire  [DATA_W-1:0]      io_port
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int PH_W  = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam int TMR_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T_PH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADR   = 3'd1;
  localparam logic [2:0] S_ADR_H = 3'd2;
  localparam logic [2:0] S_DAT   = 3'd3;
  localparam logic [2:0] S_DAT_H = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [PH_W-1:0]   ph_cnt;
  logic              is_wr, is_wr_nxt;
  logic [IDX_W-1:0]  idx;
  logic              burst_pend;
  logic [TMR_W-1:0]  tmr;
  logic [DATA_W-1:0] addr_q, addr_nxt, data_q, data_nxt, rd_addr;
  logic [DATA_W-1:0] bus_out, bus_nxt;
  logic              oe, oe_nxt;
  logic              cs_nxt, ad_nxt, rd_nxt, wr_nxt;
  logic              start_wr, start_rd;
  logic              ph_last, burst_run, tmr_wrap;
  logic [DATA_W-1:0] wr_off;
  logic              wr_in_win;
  logic [DATA_W-1:0] shadow_q [NREG];

  assign ph_last   = (ph_cnt == PH_LAST);
  assign burst_run = (idx != '0);
  assign tmr_wrap  = refresh_en && (tmr == TMR_LAST);
  assign rd_addr   = BASE_ADDR + DATA_W'(idx);
  assign wr_off    = addr_q - BASE_ADDR;
  assign wr_in_win = (32'(wr_off) < NREG);

  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    case (state)
      S_IDLE: begin
        // wr_req is ignored during the ack cycle so a held request is not replayed
        if (wr_req && !wr_ack) begin
          state_nxt = S_ADR;
          start_wr  = 1'b1;
        end else if (burst_pend || burst_run) begin
          state_nxt = S_ADR;
          start_rd  = 1'b1;
        end
      end
      S_ADR:   if (ph_last) state_nxt = S_ADR_H;
      S_ADR_H: if (ph_last) state_nxt = S_DAT;
      S_DAT:   if (ph_last) state_nxt = S_DAT_H;
      S_DAT_H: if (ph_last) state_nxt = S_GAP;
      S_GAP:   if (ph_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign is_wr_nxt = start_wr | (is_wr & ~start_rd);
  assign addr_nxt  = start_wr ? wr_addr : (start_rd ? rd_addr : addr_q);
  assign data_nxt  = start_wr ? wr_data : data_q;

  // Pad controls are decoded from the next state so they leave a flop directly
  always_comb begin
    cs_nxt = 1'b1;
    ad_nxt = 1'b1;
    rd_nxt = 1'b1;
    wr_nxt = 1'b1;
    oe_nxt = 1'b0;
    case (state_nxt)
      S_ADR: begin
        cs_nxt = 1'b0;
        ad_nxt = 1'b0;
        wr_nxt = 1'b0;
        oe_nxt = 1'b1;
      end
      S_ADR_H: begin
        cs_nxt = 1'b0;
        ad_nxt = 1'b0;
        oe_nxt = 1'b1;
      end
      S_DAT: begin
        cs_nxt = 1'b0;
        rd_nxt = is_wr_nxt;
        wr_nxt = ~is_wr_nxt;
        oe_nxt = is_wr_nxt;
      end
      S_DAT_H: begin
        cs_nxt = 1'b0;
        oe_nxt = is_wr_nxt;
      end
      default: ;
    endcase
  end

  assign bus_nxt = (state_nxt == S_ADR || state_nxt == S_ADR_H) ? addr_nxt : data_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      is_wr      <= 1'b0;
      idx        <= '0;
      burst_pend <= 1'b0;
      tmr        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      bus_out    <= '0;
      oe         <= 1'b0;
      CS         <= 1'b1;
      A_D        <= 1'b1;
      RD         <= 1'b1;
      WR         <= 1'b1;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) shadow_q[i] <= '0;
    end else begin
      state   <= state_nxt;
      ph_cnt  <= (state == S_IDLE || ph_last) ? '0 : ph_cnt + PH_W'(1);
      is_wr   <= is_wr_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      bus_out <= bus_nxt;
      oe      <= oe_nxt;
      CS      <= cs_nxt;
      A_D     <= ad_nxt;
      RD      <= rd_nxt;
      WR      <= wr_nxt;

      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;

      if (refresh_en) tmr <= tmr_wrap ? '0 : tmr + TMR_W'(1);
      if (tmr_wrap)
        burst_pend <= 1'b1;
      else if (start_rd && !burst_run)
        burst_pend <= 1'b0;

      if (state == S_DAT && ph_last && !is_wr) shadow_q[idx] <= io_port;

      if (state == S_GAP && ph_last) begin
        if (is_wr) begin
          wr_ack <= 1'b1;
          if (wr_in_win) shadow_q[wr_off[IDX_W-1:0]] <= data_q;
        end else if (idx == LAST_IDX) begin
          idx      <= '0;
          rd_valid <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign busy    = (state != S_IDLE) || burst_run;
  assign io_port = oe ? bus_out : {DATA_W{1'bz}};

  for (genvar g = 0; g < int'(NREG); g++) begin : g_shadow
    assign shadow[g*DATA_W +: DATA_W] = shadow_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_master.sv
`default_nettype none
// tb_rtc_bus_master : scoreboard bench for rtc_bus_master with a simple RTC chip model
module tb_rtc_bus_master;

  localparam int         NR   = 3;
  localparam int         TP   = 2;
  localparam int         RC   = 30;
  localparam logic [7:0] BASE = 8'h21;

  logic          clk = 1'b0;
  logic          reset;
  logic          refresh_en;
  logic          wr_req;
  logic [7:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ack, busy, rd_valid;
  logic [NR*8-1:0] shadow;
  logic          CS, A_D, RD, WR;
  wire  [7:0]    io_port;
  wire  [3:0]    stb = {CS, A_D, RD, WR};

  // Chip model: latches the address phase and returns seed + register offset on reads
  logic [7:0] chip_addr = 8'h00;
  logic [7:0] seed = 8'h00;
  assign io_port = (!CS && !RD) ? (seed + (chip_addr - BASE)) : 8'hzz;
  always @(posedge clk) if (!CS && !A_D) chip_addr <= io_port;

  rtc_bus_master #(
    .DATA_W(8), .NREG(NR), .BASE_ADDR(BASE), .T_PH(TP), .REFRESH_CYC(RC)
  ) dut (
    .clk(clk), .reset(reset), .refresh_en(refresh_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .busy(busy), .rd_valid(rd_valid), .shadow(shadow),
    .CS(CS), .A_D(A_D), .RD(RD), .WR(WR), .io_port(io_port)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] stb;
    logic       busy;
    logic       chk_bus;
    logic [7:0] bus;
    logic       ack;
    logic       vld;
  } exp_t;

  typedef struct packed {
    logic       w;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  exp_t sbq[$];
  txn_t txq[$];
  logic [7:0] exp_sh [NR];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [3:0] ph_stb(input int ph, input bit w);
    case (ph)
      0:       return 4'b0010;
      1:       return 4'b0011;
      2:       return w ? 4'b0110 : 4'b0101;
      3:       return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [NR*8-1:0] exp_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = exp_sh[i];
    return f;
  endfunction

  // Expected per-cycle view of one transaction plus the IDLE cycle that follows it
  task automatic push_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                          input bit end_busy, input bit end_vld);
    exp_t e;
    for (int ph = 0; ph < 5; ph++)
      for (int c = 0; c < TP; c++) begin
        e.stb = ph_stb(ph, w);
        e.busy = 1'b1;
        e.chk_bus = (ph < 2) || (w && ph < 4);
        e.bus = (ph < 2) ? a : d;
        e.ack = 1'b0;
        e.vld = 1'b0;
        sbq.push_back(e);
      end
    e.stb = 4'b1111; e.busy = end_busy; e.chk_bus = 1'b0; e.bus = 8'h00;
    e.ack = w; e.vld = end_vld;
    sbq.push_back(e);
  endtask

  task automatic push_burst(input logic [7:0] sd);
    for (int i = 0; i < NR; i++) begin
      push_txn(1'b0, BASE + 8'(i), 8'h00, (i != NR - 1), (i == NR - 1));
      exp_sh[i] = sd + 8'(i);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; refresh_en = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    for (int i = 0; i < NR; i++) exp_sh[i] = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({stb, wr_ack, rd_valid, busy} !== 7'b1111000) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 1111000", {stb, wr_ack, rd_valid, busy});
    end
    vectors++;
    if (shadow !== '0) begin
      miscompares++;
      $display("FAIL reset_shadow got %h want 0", shadow);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({stb, busy} !== 5'b11110) begin
      miscompares++;
      $display("FAIL reset_release_idle got %b want 11110", {stb, busy});
    end
  endtask

  task automatic test_write(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int n;
    logic [7:0] off;
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    push_txn(1'b1, a, d, 1'b0, 1'b0);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if (stb !== e.stb || busy !== e.busy || wr_ack !== e.ack || rd_valid !== e.vld ||
          (e.chk_bus && io_port !== e.bus)) begin
        miscompares++;
        $display("FAIL write_%h cyc %0d got stb=%b busy=%b ack=%b vld=%b bus=%h want stb=%b busy=%b ack=%b vld=%b bus=%h",
                 a, i, stb, busy, wr_ack, rd_valid, io_port, e.stb, e.busy, e.ack, e.vld, e.bus);
      end
      if (wr_ack) wr_req = 1'b0;
    end
    wr_req = 1'b0;
    off = a - BASE;
    if (off < NR) exp_sh[off] = d;
    vectors++;
    if (shadow !== exp_flat()) begin
      miscompares++;
      $display("FAIL write_%h_shadow got %h want %h", a, shadow, exp_flat());
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n;
    int acks;
    @(negedge clk);
    wr_addr = BASE; wr_data = 8'h3C; wr_req = 1'b1;
    push_txn(1'b1, BASE, 8'h3C, 1'b0, 1'b0);
    e.stb = 4'b1111; e.busy = 1'b0; e.chk_bus = 1'b0; e.bus = 8'h00; e.ack = 1'b0; e.vld = 1'b0;
    sbq.push_back(e);
    push_txn(1'b1, BASE + 8'd1, 8'hC4, 1'b0, 1'b0);
    n = sbq.size();
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if (stb !== e.stb || busy !== e.busy || wr_ack !== e.ack ||
          (e.chk_bus && io_port !== e.bus)) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d got stb=%b busy=%b ack=%b bus=%h want stb=%b busy=%b ack=%b bus=%h",
                 i, stb, busy, wr_ack, io_port, e.stb, e.busy, e.ack, e.bus);
      end
      if (wr_ack) begin
        acks++;
        if (acks == 1) begin wr_addr = BASE + 8'd1; wr_data = 8'hC4; end
        else wr_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    exp_sh[0] = 8'h3C; exp_sh[1] = 8'hC4;
    vectors++;
    if (shadow !== exp_flat()) begin
      miscompares++;
      $display("FAIL back_to_back_shadow got %h want %h", shadow, exp_flat());
    end
  endtask

  task automatic test_burst_and_wrap;
    exp_t e;
    int n, wait_cyc, lows, vlds;
    seed = 8'h10;
    push_burst(8'h10);
    refresh_en = 1'b1;
    wait_cyc = 0;
    while (CS !== 1'b0 && wait_cyc < 4 * RC) begin
      @(negedge clk);
      wait_cyc++;
    end
    vectors++;
    if (wait_cyc != RC + 1) begin
      miscompares++;
      $display("FAIL burst_start_latency got %0d want %0d", wait_cyc, RC + 1);
    end
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if (stb !== e.stb || busy !== e.busy || rd_valid !== e.vld ||
          (e.chk_bus && io_port !== e.bus)) begin
        miscompares++;
        $display("FAIL burst1 cyc %0d got stb=%b busy=%b vld=%b bus=%h want stb=%b busy=%b vld=%b bus=%h",
                 i, stb, busy, rd_valid, io_port, e.stb, e.busy, e.vld, e.bus);
      end
    end
    vectors++;
    if (shadow !== exp_flat()) begin
      miscompares++;
      $display("FAIL burst1_shadow got %h want %h", shadow, exp_flat());
    end
    // Timer wrapped during burst 1, so exactly one more burst must follow
    refresh_en = 1'b0;
    seed = 8'h40;
    push_burst(8'h40);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      vectors++;
      if (stb !== e.stb || busy !== e.busy || rd_valid !== e.vld ||
          (e.chk_bus && io_port !== e.bus)) begin
        miscompares++;
        $display("FAIL burst2 cyc %0d got stb=%b busy=%b vld=%b bus=%h want stb=%b busy=%b vld=%b bus=%h",
                 i, stb, busy, rd_valid, io_port, e.stb, e.busy, e.vld, e.bus);
      end
    end
    vectors++;
    if (shadow !== exp_flat()) begin
      miscompares++;
      $display("FAIL burst2_shadow got %h want %h", shadow, exp_flat());
    end
    lows = 0; vlds = 0;
    repeat (3 * RC) begin
      @(negedge clk);
      if (CS !== 1'b1 || RD !== 1'b1 || WR !== 1'b1) lows++;
      if (rd_valid) vlds++;
    end
    vectors++;
    if (lows != 0 || vlds != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL paused_quiet got strobe_low=%0d valids=%0d busy=%b want 0 0 0", lows, vlds, busy);
    end
  endtask

  task automatic test_write_mid_burst;
    txn_t t;
    logic prev_cs, cur_w;
    logic [7:0] cur_a, cur_d;
    int started, done, vlds, cyc;
    bit req1, req2;
    seed = 8'h70;
    txq.push_back({1'b0, BASE, 8'h00});
    txq.push_back({1'b0, BASE + 8'd1, 8'h00});
    refresh_en = 1'b1;
    prev_cs = 1'b1; cur_w = 1'b0; cur_a = 8'h00; cur_d = 8'h00;
    started = 0; done = 0; vlds = 0; cyc = 0; req1 = 0; req2 = 0;
    while (cyc < 20 * RC && !(done >= 5 && !busy && !wr_req)) begin
      @(negedge clk);
      cyc++;
      if (rd_valid) vlds++;
      if (wr_ack) wr_req = 1'b0;
      if (prev_cs && !CS) begin
        started++;
        cur_a = io_port; cur_w = 1'b0; cur_d = 8'h00;
        refresh_en = 1'b0;
      end
      if (!CS && A_D && !WR) begin cur_w = 1'b1; cur_d = io_port; end
      if (!prev_cs && CS) begin
        done++;
        if (txq.size() == 0) t = '0;
        else t = txq.pop_front();
        vectors++;
        if ({cur_w, cur_a, cur_d} !== {t.w, t.addr, t.data}) begin
          miscompares++;
          $display("FAIL mid_burst_txn %0d got w=%b a=%h d=%h want w=%b a=%h d=%h",
                   done, cur_w, cur_a, cur_d, t.w, t.addr, t.data);
        end
      end
      if (started == 2 && !req1) begin
        req1 = 1;
        wr_addr = BASE + 8'd2; wr_data = 8'hA5; wr_req = 1'b1;
        txq.push_back({1'b1, BASE + 8'd2, 8'hA5});
        txq.push_back({1'b0, BASE + 8'd2, 8'h00});
      end
      if (started == 4 && !req2) begin
        req2 = 1;
        wr_addr = BASE; wr_data = 8'h5A; wr_req = 1'b1;
        txq.push_back({1'b1, BASE, 8'h5A});
      end
      prev_cs = CS;
    end
    wr_req = 1'b0;
    exp_sh[0] = 8'h5A; exp_sh[1] = 8'h71; exp_sh[2] = 8'h72;
    vectors++;
    if (done != 5 || txq.size() != 0 || vlds != 1) begin
      miscompares++;
      $display("FAIL mid_burst_count got txns=%0d left=%0d valids=%0d want 5 0 1", done, txq.size(), vlds);
    end
    vectors++;
    if (shadow !== exp_flat()) begin
      miscompares++;
      $display("FAIL mid_burst_shadow got %h want %h", shadow, exp_flat());
    end
  endtask

  task automatic test_reset_mid_write;
    int cyc, acks;
    logic [7:0] first_a;
    @(negedge clk);
    wr_addr = BASE + 8'd1; wr_data = 8'hC3; wr_req = 1'b1;
    cyc = 0;
    while (!(!CS && A_D && !WR) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc >= 20) begin
      miscompares++;
      $display("FAIL reset_mid_reach_dat got timeout want DAT phase");
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({stb, wr_ack, rd_valid, busy} !== 7'b1111000 || shadow !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async got %b shadow=%h want 1111000 shadow=0",
               {stb, wr_ack, rd_valid, busy}, shadow);
    end
    wr_req = 1'b0;
    for (int i = 0; i < NR; i++) exp_sh[i] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seed = 8'h90;
    refresh_en = 1'b1;
    acks = 0; cyc = 0; first_a = 8'hFF;
    while (CS !== 1'b0 && cyc < 4 * RC) begin
      @(negedge clk);
      cyc++;
      if (wr_ack) acks++;
    end
    first_a = io_port;
    refresh_en = 1'b0;
    vectors++;
    if (acks != 0 || cyc != RC + 1 || first_a !== BASE) begin
      miscompares++;
      $display("FAIL reset_mid_restart got acks=%0d latency=%0d addr=%h want 0 %0d %h",
               acks, cyc, first_a, RC + 1, BASE);
    end
    cyc = 0;
    while (!rd_valid && cyc < 4 * RC) begin
      @(negedge clk);
      cyc++;
      if (wr_ack) acks++;
    end
    for (int i = 0; i < NR; i++) exp_sh[i] = 8'h90 + 8'(i);
    vectors++;
    if (!rd_valid || acks != 0 || shadow !== exp_flat()) begin
      miscompares++;
      $display("FAIL reset_mid_burst got valid=%b acks=%0d shadow=%h want 1 0 %h",
               rd_valid, acks, shadow, exp_flat());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write(8'h22, 8'h45);
    test_write(8'h20, 8'h11);
    test_write(8'h23, 8'h77);
    test_write(8'h24, 8'h99);
    test_back_to_back;
    test_burst_and_wrap;
    test_write_mid_burst;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
